// File: rtl/riscv_core_wb_arb.sv
// Register-file write-port arbiter: merges in-order pipeline writeback with buffered
// out-of-order MDU results, tracks pending MDU destinations and forces a drain stall on starvation.
module riscv_core_wb_arb #(
   parameter int XLEN       = 64,
   parameter int DEPTH      = 4,
   parameter int STARVE_MAX = 8
) (
   input  logic                     i_wb_clk,
   input  logic                     i_wb_rst_n,
   input  logic                     i_wb_pipe_we,
   input  logic [4:0]               i_wb_pipe_rd,
   input  logic [XLEN-1:0]          i_wb_pipe_data,
   output logic                     o_wb_pipe_stall,
   input  logic                     i_wb_mdu_valid,
   output logic                     o_wb_mdu_ready,
   input  logic [4:0]               i_wb_mdu_rd,
   input  logic [XLEN-1:0]          i_wb_mdu_data,
   input  logic                     i_wb_issue_valid,
   input  logic [4:0]               i_wb_issue_rd,
   output logic [31:0]              o_wb_busy,
   output logic [$clog2(DEPTH):0]   o_wb_fifo_cnt,
   output logic                     o_wb_rf_we3,
   output logic [4:0]               o_wb_rf_a3,
   output logic [XLEN-1:0]          o_wb_rf_wd3
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int SW = $clog2(STARVE_MAX + 1);

   logic [4:0]      fifo_rd   [DEPTH];
   logic [XLEN-1:0] fifo_data [DEPTH];
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;
   logic [CW-1:0]   cnt;
   logic [SW-1:0]   starve_cnt;
   logic            stall_q;
   logic            mdu_wr_q;
   logic [31:0]     busy;
   logic [31:0]     busy_nxt;

   logic            push;
   logic            pop;
   logic            fifo_nempty;
   logic            pipe_sel;
   logic            blocked;
   logic            starve_hit;
   logic [4:0]      head_rd;
   logic [XLEN-1:0] head_data;

   assign fifo_nempty = (cnt != '0);
   assign o_wb_mdu_ready = (cnt < CW'(DEPTH));
   assign push = i_wb_mdu_valid && o_wb_mdu_ready;
   assign pipe_sel = i_wb_pipe_we && (i_wb_pipe_rd != 5'd0);
   // A forced stall always drains the head; otherwise the pipeline owns the port.
   assign pop = fifo_nempty && (stall_q || !pipe_sel);
   assign blocked = fifo_nempty && !pop;
   assign starve_hit = blocked && (starve_cnt == SW'(STARVE_MAX - 1));
   assign head_rd = fifo_rd[rd_ptr];
   assign head_data = fifo_data[rd_ptr];

   assign o_wb_pipe_stall = stall_q;
   assign o_wb_fifo_cnt = cnt;
   assign o_wb_busy = busy;

   // Entry storage needs no reset: occupancy and pointers define what is valid.
   always_ff @(posedge i_wb_clk) begin
      if (push) begin
         fifo_rd[wr_ptr]   <= i_wb_mdu_rd;
         fifo_data[wr_ptr] <= i_wb_mdu_data;
      end
   end

   always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
      if (!i_wb_rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         if (push && !pop)      cnt <= cnt + CW'(1);
         else if (pop && !push) cnt <= cnt - CW'(1);
      end
   end

   always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
      if (!i_wb_rst_n) begin
         starve_cnt <= '0;
         stall_q    <= 1'b0;
      end else begin
         stall_q <= starve_hit;
         if (pop || starve_hit) starve_cnt <= '0;
         else if (blocked)      starve_cnt <= starve_cnt + SW'(1);
      end
   end

   always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
      if (!i_wb_rst_n) begin
         o_wb_rf_we3 <= 1'b0;
         o_wb_rf_a3  <= '0;
         o_wb_rf_wd3 <= '0;
         mdu_wr_q    <= 1'b0;
      end else begin
         mdu_wr_q <= pop && (head_rd != 5'd0);
         if (pop) begin
            o_wb_rf_we3 <= (head_rd != 5'd0);
            if (head_rd != 5'd0) begin
               o_wb_rf_a3  <= head_rd;
               o_wb_rf_wd3 <= head_data;
            end
         end else if (pipe_sel) begin
            o_wb_rf_we3 <= 1'b1;
            o_wb_rf_a3  <= i_wb_pipe_rd;
            o_wb_rf_wd3 <= i_wb_pipe_data;
         end else begin
            o_wb_rf_we3 <= 1'b0;
         end
      end
   end

   // Pending bit drops the cycle after its MDU result is visible on the write port.
   always_comb begin
      busy_nxt = busy;
      if (mdu_wr_q) busy_nxt[o_wb_rf_a3] = 1'b0;
      if (i_wb_issue_valid && (i_wb_issue_rd != 5'd0)) busy_nxt[i_wb_issue_rd] = 1'b1;
      busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
      if (!i_wb_rst_n) busy <= '0;
      else             busy <= busy_nxt;
   end

`ifndef SYNTHESIS
   issue_to_free_rd: assert property (@(posedge i_wb_clk) disable iff (!i_wb_rst_n)
      (i_wb_issue_valid && (i_wb_issue_rd != 5'd0)) |->
         (!busy[i_wb_issue_rd] || (mdu_wr_q && (o_wb_rf_a3 == i_wb_issue_rd))));

   stall_needs_entry: assert property (@(posedge i_wb_clk) disable iff (!i_wb_rst_n)
      stall_q |-> fifo_nempty);
`endif

endmodule

// File: tb/tb_riscv_core_wb_arb.sv
// Directed bench for the RF write-port arbiter: vector table plus hand-written
// starvation, full-FIFO and reset sequences.
module tb_riscv_core_wb_arb;

   logic        clk;
   logic        rst_n;
   logic        pipe_we;
   logic [4:0]  pipe_rd;
   logic [63:0] pipe_data;
   logic        stall;
   logic        mdu_valid;
   logic        mdu_ready;
   logic [4:0]  mdu_rd;
   logic [63:0] mdu_data;
   logic        issue_valid;
   logic [4:0]  issue_rd;
   logic [31:0] busy;
   logic [2:0]  fifo_cnt;
   logic        we3;
   logic [4:0]  a3;
   logic [63:0] wd3;

   int checks = 0;
   int errors = 0;

   riscv_core_wb_arb #(.XLEN(64), .DEPTH(4), .STARVE_MAX(8)) dut (
      .i_wb_clk         (clk),
      .i_wb_rst_n       (rst_n),
      .i_wb_pipe_we     (pipe_we),
      .i_wb_pipe_rd     (pipe_rd),
      .i_wb_pipe_data   (pipe_data),
      .o_wb_pipe_stall  (stall),
      .i_wb_mdu_valid   (mdu_valid),
      .o_wb_mdu_ready   (mdu_ready),
      .i_wb_mdu_rd      (mdu_rd),
      .i_wb_mdu_data    (mdu_data),
      .i_wb_issue_valid (issue_valid),
      .i_wb_issue_rd    (issue_rd),
      .o_wb_busy        (busy),
      .o_wb_fifo_cnt    (fifo_cnt),
      .o_wb_rf_we3      (we3),
      .o_wb_rf_a3       (a3),
      .o_wb_rf_wd3      (wd3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        pipe_we;
      logic [4:0]  pipe_rd;
      logic [63:0] pipe_data;
      logic        mdu_valid;
      logic [4:0]  mdu_rd;
      logic [63:0] mdu_data;
      logic        issue_valid;
      logic [4:0]  issue_rd;
      logic        we3;
      logic [4:0]  a3;
      logic [63:0] wd3;
      logic        stall;
      logic        ready;
      logic [2:0]  cnt;
      logic [31:0] busy;
   } vec_t;

   vec_t vecs[12];

   function automatic vec_t mk(input logic pw, input logic [4:0] prd, input logic [63:0] pd,
                               input logic mv, input logic [4:0] mrd, input logic [63:0] md,
                               input logic iv, input logic [4:0] ird,
                               input logic e_we, input logic [4:0] e_a3, input logic [63:0] e_wd,
                               input logic e_st, input logic e_rdy, input logic [2:0] e_cnt,
                               input logic [31:0] e_busy);
      vec_t v;
      v.pipe_we = pw;  v.pipe_rd = prd;  v.pipe_data = pd;
      v.mdu_valid = mv; v.mdu_rd = mrd; v.mdu_data = md;
      v.issue_valid = iv; v.issue_rd = ird;
      v.we3 = e_we; v.a3 = e_a3; v.wd3 = e_wd;
      v.stall = e_st; v.ready = e_rdy; v.cnt = e_cnt; v.busy = e_busy;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic e_we, input logic [4:0] e_a3,
                          input logic [63:0] e_wd, input logic e_st, input logic e_rdy,
                          input logic [2:0] e_cnt, input logic [31:0] e_busy);
      chk({tag, ".we3"},   64'(we3),       64'(e_we));
      chk({tag, ".a3"},    64'(a3),        64'(e_a3));
      chk({tag, ".wd3"},   wd3,            e_wd);
      chk({tag, ".stall"}, 64'(stall),     64'(e_st));
      chk({tag, ".ready"}, 64'(mdu_ready), 64'(e_rdy));
      chk({tag, ".cnt"},   64'(fifo_cnt),  64'(e_cnt));
      chk({tag, ".busy"},  64'(busy),      64'(e_busy));
   endtask

   task automatic drive(input logic pw, input logic [4:0] prd, input logic [63:0] pd,
                        input logic mv, input logic [4:0] mrd, input logic [63:0] md,
                        input logic iv, input logic [4:0] ird);
      pipe_we = pw; pipe_rd = prd; pipe_data = pd;
      mdu_valid = mv; mdu_rd = mrd; mdu_data = md;
      issue_valid = iv; issue_rd = ird;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // pipe: we rd data | mdu: v rd data | issue: v rd || we3 a3 wd3 stall ready cnt busy
      vecs[0]  = mk(1, 5, 64'hDEAD, 0, 0, 0,     0, 0, 1, 5, 64'hDEAD, 0, 1, 0, 32'h0);
      vecs[1]  = mk(1, 0, 64'h1234, 0, 0, 0,     0, 0, 0, 5, 64'hDEAD, 0, 1, 0, 32'h0);
      vecs[2]  = mk(0, 0, 0,        0, 0, 0,     1, 7, 0, 5, 64'hDEAD, 0, 1, 0, 32'h80);
      vecs[3]  = mk(0, 0, 0,        1, 7, 42,    0, 0, 0, 5, 64'hDEAD, 0, 1, 1, 32'h80);
      vecs[4]  = mk(0, 0, 0,        0, 0, 0,     0, 0, 1, 7, 64'd42,   0, 1, 0, 32'h80);
      vecs[5]  = mk(0, 0, 0,        0, 0, 0,     0, 0, 0, 7, 64'd42,   0, 1, 0, 32'h0);
      vecs[6]  = mk(0, 0, 0,        0, 0, 0,     1, 9, 0, 7, 64'd42,   0, 1, 0, 32'h200);
      vecs[7]  = mk(0, 0, 0,        1, 9, 'h99,  0, 0, 0, 7, 64'd42,   0, 1, 1, 32'h200);
      vecs[8]  = mk(0, 0, 0,        0, 0, 0,     0, 0, 1, 9, 64'h99,   0, 1, 0, 32'h200);
      vecs[9]  = mk(0, 0, 0,        0, 0, 0,     1, 9, 0, 9, 64'h99,   0, 1, 0, 32'h200);
      vecs[10] = mk(0, 0, 0,        1, 0, 'h55,  0, 0, 0, 9, 64'h99,   0, 1, 1, 32'h200);
      vecs[11] = mk(0, 0, 0,        0, 0, 0,     0, 0, 0, 9, 64'h99,   0, 1, 0, 32'h200);

      rst_n = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      step();
      step();
      chk_all("reset", 0, 0, 64'h0, 0, 1, 0, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 12; i++) begin
         drive(vecs[i].pipe_we, vecs[i].pipe_rd, vecs[i].pipe_data,
               vecs[i].mdu_valid, vecs[i].mdu_rd, vecs[i].mdu_data,
               vecs[i].issue_valid, vecs[i].issue_rd);
         step();
         chk_all($sformatf("vec%0d", i), vecs[i].we3, vecs[i].a3, vecs[i].wd3,
                 vecs[i].stall, vecs[i].ready, vecs[i].cnt, vecs[i].busy);
      end

      // Four MDU results arrive while the pipeline writes every cycle; the head starves.
      for (int k = 0; k < 9; k++) begin
         drive(1, 5'(k + 1), 64'h100 + 64'(k),
               (k < 4), 5'(11 + k), 64'hB0 + 64'(k), 0, 0);
         step();
         chk_all($sformatf("starve%0d", k), 1, 5'(k + 1), 64'h100 + 64'(k),
                 (k == 8), (k < 3), (k < 4) ? 3'(k + 1) : 3'd4, 32'h200);
      end
      drive(1, 20, 64'h200, 0, 0, 0, 0, 0);
      step();
      chk_all("forced_drain", 1, 11, 64'hB0, 0, 1, 3, 32'h200);

      // Refill to full, then offer a result in a cycle that pops: no push while full.
      drive(1, 21, 64'h300, 1, 15, 64'hB4, 0, 0);
      step();
      chk_all("refill", 1, 21, 64'h300, 0, 0, 4, 32'h200);
      drive(0, 0, 0, 1, 16, 64'hC0, 0, 0);
      step();
      chk_all("full_pop", 1, 12, 64'hB1, 0, 1, 3, 32'h200);
      drive(1, 22, 64'h301, 1, 16, 64'hC0, 0, 0);
      step();
      chk_all("push_after", 1, 22, 64'h301, 0, 0, 4, 32'h200);
      drive(0, 0, 0, 0, 0, 0, 1, 7);
      step();
      chk_all("pre_reset", 1, 13, 64'hB2, 0, 1, 3, 32'h280);

      // Asynchronous reset mid-operation drops everything without a clock edge.
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      #2;
      rst_n = 1'b0;
      #1;
      chk_all("async_reset", 0, 0, 64'h0, 0, 1, 0, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      chk_all("post_reset", 0, 0, 64'h0, 0, 1, 0, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
